pc_source_ctrl: RTL and testbench
=================================

// Module: pc_source_ctrl
// PURPOSE
//  Drives the PC-source select and PC/EPC write strobes of the multicycle MIPS datapath.
//  Main control raises step in each instruction's PC-update phase. This block resolves the next-PC source:
//  sequential, branch, jump, JR, RTE or an exception vector. For exceptions it sequences EPC save, vector read and PC load.
//  Sits between main control/decoder and the PC-source mux + PC/EPC registers.
// PARAMETERS
//  MEM_WAIT   2        cycles from mem_addr valid to MemDataReg valid (>=1)
//  VEC_OPCODE 32'd253  byte address holding the invalid-opcode handler address
//  VEC_OVF    32'd254  byte address holding the overflow handler address
//  VEC_DIV0   32'd255  byte address holding the divide-by-zero handler address
// PORTS
//  clk          in   1  rising-edge clock
//  reset        in   1  asynchronous, active-low reset
//  step         in   1  1-cycle pulse: PC-update phase of current instruction
//  op_kind      in   3  0 SEQ,1 BEQ,2 BNE,3 J,4 JR,5 RTE,6-7 treated as SEQ
//  zero         in   1  ALU zero flag for BEQ/BNE, sampled with step
//  exc_opcode   in   1  invalid opcode detected, sampled with step
//  exc_ovf      in   1  arithmetic overflow, sampled with step
//  exc_div0     in   1  divide by zero, sampled with step
//  pc_source    out  3  000 PC,001 ALU(PC+4),010 EPC,011 MemDataReg,100 ALUOut
//  pc_write     out  1  PC load strobe
//  epc_write    out  1  EPC load strobe (datapath presents PC-4 on ALU)
//  mem_addr_sel out  1  1: memory address driven by exc_addr
//  exc_addr     out  32 vector byte address
//  busy         out  1  high from accepted step until done
//  done         out  1  1-cycle pulse: PC update complete
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 (pc_source=000, exc_addr=0); wait counter cleared.
//  Reset mid-operation aborts immediately. No PC/EPC strobe is issued after reset is asserted.
//  States: IDLE, UPDATE, EXC_SAVE, EXC_READ, EXC_LOAD.
//  IDLE:
//   - On step with any exc_* set -> EXC_SAVE.
//   - On step with no exc_* set -> UPDATE.
//   - step while busy is ignored.
//  Exception priority: opcode > ovf > div0. exc_addr is latched from the winner at step.
//  An exception beats any op_kind presented in the same cycle.
//  UPDATE (1 cycle): pc_write=1, done=1, then -> IDLE. pc_source by op_kind:
//   - SEQ -> 001.
//   - BEQ: zero ? 100 : 001.
//   - BNE: !zero ? 100 : 001.
//   - J -> 100.
//   - JR -> 001 (ALU passes rs).
//   - RTE -> 010.
//   zero is registered at step; later changes are ignored.
//  EXC_SAVE (1 cycle): epc_write=1, pc_write=0 -> EXC_READ.
//  EXC_READ (MEM_WAIT cycles): mem_addr_sel=1, counter counts MEM_WAIT-1 down to 0 -> EXC_LOAD.
//  EXC_LOAD (1 cycle): pc_source=011, pc_write=1, done=1 -> IDLE.
//   MemDataReg holds the zero-extended byte read.
//  Latency: normal path, step at N -> pc_write/done at N+1.
//   Exception path, step at N -> epc_write at N+1, pc_write/done at N+2+MEM_WAIT.
//  Outputs are registered. pc_write and epc_write are never high in the same cycle.
//  pc_source returns to 000 whenever pc_write=0.
//  busy=1 in every non-IDLE state. A step in the same cycle as done is ignored.
// STRUCTURE
//  Shared package/header: op_kind codes, PCSource codes (000-100), vector constants.
//  Keep the PCSource codes common with the PC-source mux select encoding.
//  Single module: one FSM plus a $clog2(MEM_WAIT+1)-bit wait counter; no sub-module.
// TESTING
//  - Reset low mid-EXC_READ -> next cycle all outputs 0, state IDLE. After release, step SEQ -> pc_source=001, pc_write at N+1.
//  - step BEQ zero=1 -> pc_source=100, pc_write=1, done=1 at N+1.
//    BEQ zero=0 -> 001. BNE zero=0 -> 100.
//  - step RTE -> pc_source=010 at N+1; J -> 100; op_kind=7 -> 001.
//  - step with exc_ovf=1 and exc_div0=1 (MEM_WAIT=2):
//    epc_write at N+1; mem_addr_sel=1 with exc_addr=254 at N+2..N+3; pc_source=011 + pc_write at N+4.
//  - exc_opcode=1 with op_kind=J -> exc_addr=253, no pc_source=100 issued.
//    A second step during busy produces no extra done.
//  - Assertions: pc_write&epc_write never both high; done only with pc_write; pc_source==000 when !pc_write.

Source files
------------

// File: rtl/pc_source_ctrl_pkg.sv
// Shared encodings for the PC-update control path.
// The op_kind decoder, the PC-source mux and the controller use these constants.
package pc_source_ctrl_pkg;

    // op_kind codes from the main decoder; codes 6 and 7 behave as SEQ
    localparam logic [2:0] OP_SEQ = 3'd0;
    localparam logic [2:0] OP_BEQ = 3'd1;
    localparam logic [2:0] OP_BNE = 3'd2;
    localparam logic [2:0] OP_J   = 3'd3;
    localparam logic [2:0] OP_JR  = 3'd4;
    localparam logic [2:0] OP_RTE = 3'd5;

    // PC-source mux select encoding, shared with the datapath mux
    localparam logic [2:0] PCS_PC     = 3'b000;
    localparam logic [2:0] PCS_ALU    = 3'b001;
    localparam logic [2:0] PCS_EPC    = 3'b010;
    localparam logic [2:0] PCS_MDR    = 3'b011;
    localparam logic [2:0] PCS_ALUOUT = 3'b100;

    // Default byte addresses of the exception handler vectors
    localparam logic [31:0] VEC_OPCODE_DEF = 32'd253;
    localparam logic [31:0] VEC_OVF_DEF    = 32'd254;
    localparam logic [31:0] VEC_DIV0_DEF   = 32'd255;

    // Next-PC source for a non-exception update
    function automatic logic [2:0] pc_source_for(input logic [2:0] op, input logic zero);
        logic [2:0] src;
        case (op)
            OP_BEQ:  src = zero ? PCS_ALUOUT : PCS_ALU;
            OP_BNE:  src = zero ? PCS_ALU : PCS_ALUOUT;
            OP_J:    src = PCS_ALUOUT;
            OP_JR:   src = PCS_ALU;
            OP_RTE:  src = PCS_EPC;
            default: src = PCS_ALU;
        endcase
        return src;
    endfunction

endpackage

// File: rtl/pc_source_ctrl_if.sv
// Bundle between main control and the PC-source controller.
// master: main control / decoder side; slave: pc_source_ctrl.
interface pc_source_ctrl_if;
    logic        step;
    logic [2:0]  op_kind;
    logic        zero;
    logic        exc_opcode;
    logic        exc_ovf;
    logic        exc_div0;
    logic [2:0]  pc_source;
    logic        pc_write;
    logic        epc_write;
    logic        mem_addr_sel;
    logic [31:0] exc_addr;
    logic        busy;
    logic        done;

    modport master (
        output step, op_kind, zero, exc_opcode, exc_ovf, exc_div0,
        input  pc_source, pc_write, epc_write, mem_addr_sel, exc_addr, busy, done
    );

    modport slave (
        input  step, op_kind, zero, exc_opcode, exc_ovf, exc_div0,
        output pc_source, pc_write, epc_write, mem_addr_sel, exc_addr, busy, done
    );
endinterface

// File: rtl/pc_source_ctrl.sv
// Next-PC source controller for the multicycle MIPS datapath.
// Normal updates take one cycle; exceptions save EPC, read the handler
// vector from memory and load it into PC. All outputs are registered and
// computed from the next state, so they line up with the state they belong to.
module pc_source_ctrl
    import pc_source_ctrl_pkg::*;
#(
    parameter int          MEM_WAIT   = 2,
    parameter logic [31:0] VEC_OPCODE = VEC_OPCODE_DEF,
    parameter logic [31:0] VEC_OVF    = VEC_OVF_DEF,
    parameter logic [31:0] VEC_DIV0   = VEC_DIV0_DEF
) (
    input  logic              clk,
    input  logic              reset,
    pc_source_ctrl_if.slave   bus
);

    localparam int CNT_W = $clog2(MEM_WAIT + 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_UPDATE   = 3'd1;
    localparam logic [2:0] S_EXC_SAVE = 3'd2;
    localparam logic [2:0] S_EXC_READ = 3'd3;
    localparam logic [2:0] S_EXC_LOAD = 3'd4;

    logic [2:0]       state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;

    logic [2:0]  pc_source_q, pc_source_nx;
    logic        pc_write_q, pc_write_nx;
    logic        epc_write_q, epc_write_nx;
    logic        mem_addr_sel_q, mem_addr_sel_nx;
    logic [31:0] exc_addr_q, exc_addr_nx;
    logic        busy_q, busy_nx;
    logic        done_q, done_nx;

    logic        any_exc;
    logic [31:0] exc_vec;

    // Exception vector selection: opcode beats overflow beats divide-by-zero
    always_comb begin
        any_exc = bus.exc_opcode | bus.exc_ovf | bus.exc_div0;
        if (bus.exc_opcode)
            exc_vec = VEC_OPCODE;
        else if (bus.exc_ovf)
            exc_vec = VEC_OVF;
        else
            exc_vec = VEC_DIV0;
    end

    // Next-state and next-output decode; step is only honoured in IDLE
    always_comb begin
        state_nx        = state;
        cnt_nx          = cnt;
        exc_addr_nx     = exc_addr_q;
        pc_source_nx    = PCS_PC;
        pc_write_nx     = 1'b0;
        epc_write_nx    = 1'b0;
        mem_addr_sel_nx = 1'b0;
        busy_nx         = 1'b0;
        done_nx         = 1'b0;

        case (state)
            S_IDLE: begin
                if (bus.step) begin
                    busy_nx = 1'b1;
                    if (any_exc) begin
                        // Exception wins over whatever op_kind says
                        state_nx     = S_EXC_SAVE;
                        exc_addr_nx  = exc_vec;
                        epc_write_nx = 1'b1;
                    end else begin
                        // zero is consumed here, so later changes cannot matter
                        state_nx     = S_UPDATE;
                        pc_source_nx = pc_source_for(bus.op_kind, bus.zero);
                        pc_write_nx  = 1'b1;
                        done_nx      = 1'b1;
                    end
                end
            end

            S_UPDATE: begin
                state_nx = S_IDLE;
            end

            S_EXC_SAVE: begin
                state_nx        = S_EXC_READ;
                cnt_nx          = CNT_W'(MEM_WAIT - 1);
                mem_addr_sel_nx = 1'b1;
                busy_nx         = 1'b1;
            end

            S_EXC_READ: begin
                busy_nx = 1'b1;
                if (cnt == '0) begin
                    // Vector byte is now in MemDataReg
                    state_nx     = S_EXC_LOAD;
                    pc_source_nx = PCS_MDR;
                    pc_write_nx  = 1'b1;
                    done_nx      = 1'b1;
                end else begin
                    cnt_nx          = cnt - CNT_W'(1);
                    mem_addr_sel_nx = 1'b1;
                end
            end

            S_EXC_LOAD: begin
                state_nx = S_IDLE;
            end

            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // State, wait counter and registered outputs; reset aborts any sequence at once
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= S_IDLE;
            cnt            <= '0;
            pc_source_q    <= PCS_PC;
            pc_write_q     <= 1'b0;
            epc_write_q    <= 1'b0;
            mem_addr_sel_q <= 1'b0;
            exc_addr_q     <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state          <= state_nx;
            cnt            <= cnt_nx;
            pc_source_q    <= pc_source_nx;
            pc_write_q     <= pc_write_nx;
            epc_write_q    <= epc_write_nx;
            mem_addr_sel_q <= mem_addr_sel_nx;
            exc_addr_q     <= exc_addr_nx;
            busy_q         <= busy_nx;
            done_q         <= done_nx;
        end
    end

    assign bus.pc_source    = pc_source_q;
    assign bus.pc_write     = pc_write_q;
    assign bus.epc_write    = epc_write_q;
    assign bus.mem_addr_sel = mem_addr_sel_q;
    assign bus.exc_addr     = exc_addr_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;

endmodule

// File: tb/tb_pc_source_ctrl.sv
// Directed bench for pc_source_ctrl with MEM_WAIT=2 and default vectors.
module tb_pc_source_ctrl;

    logic clk;
    logic reset;
    int   nchk;
    int   nerr;

    pc_source_ctrl_if bus ();

    pc_source_ctrl #(
        .MEM_WAIT   (2),
        .VEC_OPCODE (32'd253),
        .VEC_OVF    (32'd254),
        .VEC_DIV0   (32'd255)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // advance one clock and settle just after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.step       = 1'b0;
        bus.op_kind    = 3'd0;
        bus.zero       = 1'b0;
        bus.exc_opcode = 1'b0;
        bus.exc_ovf    = 1'b0;
        bus.exc_div0   = 1'b0;
    endtask

    // present a one-cycle step; returns just after the edge that samples it
    task automatic do_step(input logic [2:0] op, input logic z,
                           input logic eo, input logic ev, input logic ed);
        bus.step       = 1'b1;
        bus.op_kind    = op;
        bus.zero       = z;
        bus.exc_opcode = eo;
        bus.exc_ovf    = ev;
        bus.exc_div0   = ed;
        tick();
        clear_inputs();
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".pc_source"},    32'(bus.pc_source),    32'd0);
        chk({tag, ".pc_write"},     32'(bus.pc_write),     32'd0);
        chk({tag, ".epc_write"},    32'(bus.epc_write),    32'd0);
        chk({tag, ".mem_addr_sel"}, 32'(bus.mem_addr_sel), 32'd0);
        chk({tag, ".busy"},         32'(bus.busy),         32'd0);
        chk({tag, ".done"},         32'(bus.done),         32'd0);
    endtask

    // normal update: step at N, strobes at N+1, idle at N+2
    task automatic normal_case(input string tag, input logic [2:0] op, input logic z,
                               input logic [2:0] exp_src);
        do_step(op, z, 1'b0, 1'b0, 1'b0);
        chk({tag, ".pc_source"}, 32'(bus.pc_source), 32'(exp_src));
        chk({tag, ".pc_write"},  32'(bus.pc_write),  32'd1);
        chk({tag, ".done"},      32'(bus.done),      32'd1);
        chk({tag, ".epc_write"}, 32'(bus.epc_write), 32'd0);
        tick();
        chk_idle({tag, ".after"});
    endtask

    // invariants checked on every falling edge while out of reset
    always @(negedge clk) begin
        if (reset) begin
            nchk++;
            assert (!(bus.pc_write && bus.epc_write))
            else begin
                nerr++;
                $error("FAIL inv.pcw_epcw observed=1 expected=0");
            end
            nchk++;
            assert (!bus.done || bus.pc_write)
            else begin
                nerr++;
                $error("FAIL inv.done_wo_pcw observed=%0d expected=1", bus.pc_write);
            end
            nchk++;
            assert (bus.pc_write || bus.pc_source === 3'b000)
            else begin
                nerr++;
                $error("FAIL inv.pcsrc_idle observed=%0d expected=0", bus.pc_source);
            end
        end
    end

    initial begin
        int n_done;
        int n_aluout;
        nchk = 0;
        nerr = 0;
        reset = 1'b0;
        clear_inputs();

        // reset state
        tick();
        tick();
        chk_idle("rst");
        chk("rst.exc_addr", bus.exc_addr, 32'd0);
        reset = 1'b1;
        tick();

        // reset asserted in the middle of EXC_READ
        do_step(3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("rd.epc_write", 32'(bus.epc_write), 32'd1);
        chk("rd.exc_addr",  bus.exc_addr,       32'd255);
        tick();
        chk("rd.mem_addr_sel", 32'(bus.mem_addr_sel), 32'd1);
        reset = 1'b0;
        tick();
        chk_idle("midrst");
        chk("midrst.exc_addr", bus.exc_addr, 32'd0);
        tick();
        chk("midrst.pc_write2", 32'(bus.pc_write), 32'd0);
        reset = 1'b1;
        tick();

        // normal updates
        normal_case("seq",  3'd0, 1'b0, 3'b001);
        normal_case("beq1", 3'd1, 1'b1, 3'b100);
        normal_case("beq0", 3'd1, 1'b0, 3'b001);
        normal_case("bne0", 3'd2, 1'b0, 3'b100);
        normal_case("bne1", 3'd2, 1'b1, 3'b001);
        normal_case("j",    3'd3, 1'b0, 3'b100);
        normal_case("jr",   3'd4, 1'b1, 3'b001);
        normal_case("rte",  3'd5, 1'b0, 3'b010);
        normal_case("op6",  3'd6, 1'b1, 3'b001);
        normal_case("op7",  3'd7, 1'b0, 3'b001);

        // overflow + divide-by-zero: overflow vector wins, full sequence timing
        do_step(3'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("ovf.n1.epc_write",    32'(bus.epc_write),    32'd1);
        chk("ovf.n1.pc_write",     32'(bus.pc_write),     32'd0);
        chk("ovf.n1.mem_addr_sel", 32'(bus.mem_addr_sel), 32'd0);
        chk("ovf.n1.busy",         32'(bus.busy),         32'd1);
        chk("ovf.n1.exc_addr",     bus.exc_addr,          32'd254);
        tick();
        chk("ovf.n2.mem_addr_sel", 32'(bus.mem_addr_sel), 32'd1);
        chk("ovf.n2.epc_write",    32'(bus.epc_write),    32'd0);
        chk("ovf.n2.exc_addr",     bus.exc_addr,          32'd254);
        tick();
        chk("ovf.n3.mem_addr_sel", 32'(bus.mem_addr_sel), 32'd1);
        chk("ovf.n3.pc_write",     32'(bus.pc_write),     32'd0);
        tick();
        chk("ovf.n4.pc_source",    32'(bus.pc_source),    32'd3);
        chk("ovf.n4.pc_write",     32'(bus.pc_write),     32'd1);
        chk("ovf.n4.done",         32'(bus.done),         32'd1);
        chk("ovf.n4.mem_addr_sel", 32'(bus.mem_addr_sel), 32'd0);
        tick();
        chk_idle("ovf.n5");

        // invalid opcode with J, plus a stray step while busy
        do_step(3'd3, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("opc.exc_addr",  bus.exc_addr,       32'd253);
        chk("opc.epc_write", 32'(bus.epc_write), 32'd1);
        n_done = 0;
        n_aluout = 0;
        bus.step    = 1'b1;
        bus.op_kind = 3'd3;
        tick();
        clear_inputs();
        for (int i = 0; i < 8; i++) begin
            if (bus.done) n_done++;
            if (bus.pc_source == 3'b100) n_aluout++;
            if (bus.pc_source == 3'b011) chk("opc.load_addr", bus.exc_addr, 32'd253);
            tick();
        end
        chk("opc.done_count",   32'(n_done),   32'd1);
        chk("opc.aluout_count", 32'(n_aluout), 32'd0);
        chk_idle("opc.end");

        // step coinciding with done is ignored
        do_step(3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("coinc.done", 32'(bus.done), 32'd1);
        do_step(3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_idle("coinc.after");
        tick();
        chk("coinc.later.pc_write", 32'(bus.pc_write), 32'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
